// File: rtl/acc_pkg.sv
// Shared definitions for the acc_send schedulers: opcodes, response codes, FSM encodings.
// Request validation lives here so the receive-side scheduler applies the same rules.
package acc_pkg;

   localparam logic [2:0] OP_EAGER = 3'b010;
   localparam logic [2:0] OP_MEM   = 3'b011;

   typedef enum logic [1:0] {
      ERR_OK      = 2'd0,
      ERR_OPCODE  = 2'd1,
      ERR_SIZE    = 2'd2,
      ERR_TIMEOUT = 2'd3
   } rsp_err_e;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CHECK = 3'd1,
      S_ISSUE = 3'd2,
      S_BUSY  = 3'd3,
      S_RESP  = 3'd4
   } sched_state_e;

   // A zero-length memory send would never complete in the engine, so it is refused up front.
   function automatic rsp_err_e check_req(input logic [2:0] op, input logic [10:0] size);
      if (op != OP_EAGER && op != OP_MEM) return ERR_OPCODE;
      if (op == OP_MEM && size == '0) return ERR_SIZE;
      return ERR_OK;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, wrapping.
// Shared by the send- and receive-side schedulers.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    last_grant,
   output logic [ID_W-1:0]    grant,
   output logic               any_req
);

   logic [ID_W:0]   sum;
   logic [ID_W-1:0] idx;

   // Scan from the farthest offset down so the nearest pending requester overwrites last.
   always_comb begin
      grant = last_grant;
      sum   = '0;
      idx   = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         sum = {1'b0, last_grant} + (ID_W+1)'(k);
         if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
         idx = sum[ID_W-1:0];
         if (req[idx]) grant = idx;
      end
   end

   assign any_req = |req;

endmodule

// File: rtl/acc_send_sched.sv
// Round-robin scheduler sharing one acc_send engine among NUM_REQ requesters.
// Optional build macro ACC_SEND_TIMEOUT_EN adds a BUSY watchdog and the timeout_flag port.
module acc_send_sched
   import acc_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int ID_W           = 2,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                 nios_clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ*32-1:0] req_head,
   input  logic [NUM_REQ*32-1:0] req_ptr,
   input  logic [NUM_REQ*3-1:0] req_opcode,
   output logic [NUM_REQ-1:0]   req_ack,
   output logic [31:0]          rsp_result,
   output logic [1:0]           rsp_err,
   output logic [ID_W-1:0]      rsp_id,
   output logic                 busy,
   output logic                 eng_clk_en,
   output logic                 eng_start,
   output logic [31:0]          eng_head,
   output logic [31:0]          eng_ptr,
   output logic [2:0]           eng_opcode,
   input  logic                 eng_done,
   input  logic [31:0]          eng_result
`ifdef ACC_SEND_TIMEOUT_EN
   ,
   output logic                 timeout_flag
`endif
);

   sched_state_e    state;
   logic [ID_W-1:0] grant, last_grant, arb_grant;
   logic            any_req;
   rsp_err_e        chk_err;
`ifdef ACC_SEND_TIMEOUT_EN
   logic [12:0]     busy_cnt;
`endif

   rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
      .req        (req_valid),
      .last_grant (last_grant),
      .grant      (arb_grant),
      .any_req    (any_req)
   );

   // The engine operand registers double as the latched request.
   assign chk_err = check_req(eng_opcode, eng_ptr[10:0]);

   always_ff @(posedge nios_clk) begin
      if (reset) begin
         state      <= S_IDLE;
         grant      <= '0;
         last_grant <= ID_W'(NUM_REQ-1);
         req_ack    <= '0;
         rsp_result <= '0;
         rsp_err    <= '0;
         rsp_id     <= '0;
         busy       <= 1'b0;
         eng_clk_en <= 1'b0;
         eng_start  <= 1'b0;
         eng_head   <= '0;
         eng_ptr    <= '0;
         eng_opcode <= '0;
`ifdef ACC_SEND_TIMEOUT_EN
         busy_cnt     <= '0;
         timeout_flag <= 1'b0;
`endif
      end else begin
         req_ack   <= '0;
         eng_start <= 1'b0;
         case (state)
            S_IDLE: if (any_req) begin
               grant      <= arb_grant;
               eng_head   <= req_head[32*arb_grant +: 32];
               eng_ptr    <= req_ptr[32*arb_grant +: 32];
               eng_opcode <= req_opcode[3*arb_grant +: 3];
               busy       <= 1'b1;
               state      <= S_CHECK;
            end
            S_CHECK: if (chk_err != ERR_OK) begin
               req_ack    <= NUM_REQ'(1) << grant;
               rsp_id     <= grant;
               rsp_err    <= chk_err;
               rsp_result <= '0;
               state      <= S_RESP;
            end else begin
               eng_clk_en <= 1'b1;
               eng_start  <= 1'b1;
`ifdef ACC_SEND_TIMEOUT_EN
               busy_cnt   <= '0;
`endif
               state      <= S_ISSUE;
            end
            S_ISSUE: state <= S_BUSY;
            S_BUSY: if (eng_done) begin
               eng_clk_en <= 1'b0;
               req_ack    <= NUM_REQ'(1) << grant;
               rsp_id     <= grant;
               rsp_err    <= ERR_OK;
               rsp_result <= eng_result;
               state      <= S_RESP;
            end
`ifdef ACC_SEND_TIMEOUT_EN
            else if (busy_cnt == 13'(TIMEOUT_CYCLES-1)) begin
               eng_clk_en   <= 1'b0;
               req_ack      <= NUM_REQ'(1) << grant;
               rsp_id       <= grant;
               rsp_err      <= ERR_TIMEOUT;
               rsp_result   <= '0;
               timeout_flag <= 1'b1;
               state        <= S_RESP;
            end else begin
               busy_cnt <= busy_cnt + 13'd1;
            end
`endif
            S_RESP: begin
               last_grant <= grant;
               rsp_result <= '0;
               rsp_err    <= '0;
               rsp_id     <= '0;
               busy       <= 1'b0;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_acc_send_sched.sv
// Self-checking bench for acc_send_sched: directed table, round-robin/reset sequences, random traffic.
// Build with ACC_SEND_TIMEOUT_EN to also exercise the watchdog.
module tb_acc_send_sched;

   localparam int N   = 4;
   localparam int IDW = 2;
   localparam int TO  = 16;

   logic             nios_clk = 1'b0;
   logic             reset = 1'b1;
   logic [N-1:0]     req_valid = '0;
   logic [N*32-1:0]  req_head = '0;
   logic [N*32-1:0]  req_ptr = '0;
   logic [N*3-1:0]   req_opcode = '0;
   logic [N-1:0]     req_ack;
   logic [31:0]      rsp_result;
   logic [1:0]       rsp_err;
   logic [IDW-1:0]   rsp_id;
   logic             busy, eng_clk_en, eng_start;
   logic [31:0]      eng_head, eng_ptr;
   logic [2:0]       eng_opcode;
   logic             eng_done;
   logic             eng_done_m = 1'b0;
   logic             stray_done = 1'b0;
   logic [31:0]      eng_result = '0;
`ifdef ACC_SEND_TIMEOUT_EN
   logic             timeout_flag;
`endif

   assign eng_done = eng_done_m | stray_done;

   always #5 nios_clk = ~nios_clk;

   acc_send_sched #(.NUM_REQ(N), .ID_W(IDW), .TIMEOUT_CYCLES(TO)) dut (
      .nios_clk   (nios_clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_head   (req_head),
      .req_ptr    (req_ptr),
      .req_opcode (req_opcode),
      .req_ack    (req_ack),
      .rsp_result (rsp_result),
      .rsp_err    (rsp_err),
      .rsp_id     (rsp_id),
      .busy       (busy),
      .eng_clk_en (eng_clk_en),
      .eng_start  (eng_start),
      .eng_head   (eng_head),
      .eng_ptr    (eng_ptr),
      .eng_opcode (eng_opcode),
      .eng_done   (eng_done),
      .eng_result (eng_result)
`ifdef ACC_SEND_TIMEOUT_EN
      ,
      .timeout_flag (timeout_flag)
`endif
   );

   // Engine model: done eng_lat cycles after start (0 = never); eager echoes ptr, memory returns head^ptr.
   int          eng_lat = 2;
   int          e_cnt = 0;
   logic [31:0] e_res = '0;
   always @(posedge nios_clk) begin
      eng_done_m <= 1'b0;
      if (reset) e_cnt <= 0;
      else if (eng_start) begin
         e_cnt <= eng_lat;
         e_res <= (eng_opcode == 3'b010) ? eng_ptr : (eng_head ^ eng_ptr);
      end else if (e_cnt > 0) begin
         e_cnt <= e_cnt - 1;
         if (e_cnt == 1) begin
            eng_done_m <= 1'b1;
            eng_result <= e_res;
         end
      end
   end

   int          nvec = 0, nmis = 0;
   int          model_last = N-1;
   bit          exp_valid = 0, busy_q = 0, to_mode = 0;
   int          exp_grant = 0, starts = 0, clk_cyc = 0;
   logic [31:0] last_res = '0;
   logic [1:0]  last_err = '0;
   logic [IDW-1:0] last_id = '0;
   int          ack_log[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++)
         if (v[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   function automatic int exp_err(input logic [2:0] op, input logic [31:0] p);
      if (op != 3'b010 && op != 3'b011) return 1;
      if (op == 3'b011 && p[10:0] == 11'd0) return 2;
      return 0;
   endfunction

   task automatic post(input int i, input logic [2:0] op, input logic [31:0] h, input logic [31:0] p);
      req_head[32*i +: 32] = h;
      req_ptr[32*i +: 32]  = p;
      req_opcode[3*i +: 3] = op;
      req_valid[i]         = 1'b1;
   endtask

   // One clock: observe at negedge, compare against the model, retire acked requests.
   task automatic tick();
      int          e;
      logic [31:0] r, h, p;
      logic [2:0]  op;
      @(negedge nios_clk);
      if (busy && !busy_q) begin
         exp_grant = rr_pick(req_valid, model_last);
         exp_valid = (exp_grant >= 0);
         starts    = 0;
         clk_cyc   = 0;
      end
      if (eng_clk_en) clk_cyc++;
      if (eng_start && exp_valid) begin
         starts++;
         chk("eng_head", eng_head, req_head[32*exp_grant +: 32]);
         chk("eng_ptr", eng_ptr, req_ptr[32*exp_grant +: 32]);
         chk("eng_opcode", 32'(eng_opcode), 32'(req_opcode[3*exp_grant +: 3]));
      end
      if (req_ack != '0) begin
         if (!exp_valid) begin
            nvec++; nmis++;
            $display("FAIL unexpected_ack: got ack 0x%0h expected none", req_ack);
         end else begin
            op = req_opcode[3*exp_grant +: 3];
            h  = req_head[32*exp_grant +: 32];
            p  = req_ptr[32*exp_grant +: 32];
            e  = exp_err(op, p);
            r  = (e != 0) ? 32'd0 : ((op == 3'b010) ? p : (h ^ p));
            if (e == 0 && to_mode) begin
               e = 3;
               r = 0;
               chk("busy_cycles", 32'(clk_cyc), 32'(TO + 1));
            end
            chk("ack_onehot", 32'(req_ack), 32'(1) << exp_grant);
            chk("rsp_id", 32'(rsp_id), 32'(exp_grant));
            chk("rsp_err", 32'(rsp_err), 32'(e));
            chk("rsp_result", rsp_result, r);
            chk("start_count", 32'(starts), (e == 0 || e == 3) ? 32'd1 : 32'd0);
            last_res = rsp_result;
            last_err = rsp_err;
            last_id  = rsp_id;
            ack_log.push_back(exp_grant);
            model_last = exp_grant;
            req_valid[exp_grant] = 1'b0;
            exp_valid = 0;
         end
      end
      busy_q = busy;
   endtask

   task automatic wait_idle(input string nm, input int bound);
      for (int k = 0; k < bound; k++) begin
         tick();
         if (req_valid == '0 && !busy) return;
      end
      nvec++; nmis++;
      $display("FAIL %s_timeout: requests 0x%0h still pending, expected all acked", nm, req_valid);
   endtask

   task automatic apply_reset();
      reset      = 1'b1;
      req_valid  = '0;
      stray_done = 1'b0;
      @(negedge nios_clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ack", 32'(req_ack), 32'd0);
      chk("rst_eng_ctl", {27'd0, eng_clk_en, eng_start, eng_opcode}, 32'd0);
      chk("rst_eng_head", eng_head, 32'd0);
      chk("rst_eng_ptr", eng_ptr, 32'd0);
      chk("rst_rsp_result", rsp_result, 32'd0);
      chk("rst_rsp_meta", {28'd0, rsp_err, rsp_id}, 32'd0);
      reset      = 1'b0;
      model_last = N-1;
      exp_valid  = 0;
      busy_q     = 0;
   endtask

   typedef struct {
      int          idx;
      logic [2:0]  op;
      logic [31:0] head;
      logic [31:0] ptr;
      int          lat;
      logic [1:0]  err;
      logic [31:0] res;
   } vec_t;

   vec_t tbl[7];
   int   reassert_done;

   initial begin
      tbl[0] = '{0, 3'b010, 32'hA0B0C0D0, 32'h00001234, 2, 2'd0, 32'h00001234};
      tbl[1] = '{2, 3'b011, 32'h11112222, 32'h00020003, 5, 2'd0, 32'h11132221};
      tbl[2] = '{1, 3'b101, 32'h0000BEEF, 32'h00000005, 2, 2'd1, 32'h0};
      tbl[3] = '{3, 3'b011, 32'h12345678, 32'h00020000, 2, 2'd2, 32'h0};
      tbl[4] = '{3, 3'b000, 32'hFFFFFFFF, 32'h00000001, 2, 2'd1, 32'h0};
      tbl[5] = '{1, 3'b011, 32'h00000000, 32'h000007FF, 3, 2'd0, 32'h000007FF};
      tbl[6] = '{0, 3'b011, 32'hCAFEF00D, 32'hFFFFF800, 2, 2'd2, 32'h0};

      apply_reset();
`ifdef ACC_SEND_TIMEOUT_EN
      chk("rst_timeout_flag", 32'(timeout_flag), 32'd0);
`endif

      // Directed single requests
      foreach (tbl[t]) begin
         eng_lat = tbl[t].lat;
         post(tbl[t].idx, tbl[t].op, tbl[t].head, tbl[t].ptr);
         wait_idle("tbl", 60);
         chk("tbl_id", 32'(last_id), 32'(tbl[t].idx));
         chk("tbl_err", 32'(last_err), 32'(tbl[t].err));
         chk("tbl_res", last_res, tbl[t].res);
      end

      // All four pending, then requester 1 re-asserts right at its ack
      apply_reset();
      ack_log.delete();
      eng_lat = 2;
      for (int i = 0; i < N; i++) post(i, 3'b010, 32'(i * 16), 32'(100 + i));
      reassert_done = 0;
      for (int k = 0; k < 200 && ack_log.size() < 5; k++) begin
         tick();
         if (reassert_done == 0 && ack_log.size() == 2 && ack_log[1] == 1) begin
            post(1, 3'b010, 32'h55, 32'h77);
            reassert_done = 1;
         end
      end
      chk("rr_count", 32'(ack_log.size()), 32'd5);
      if (ack_log.size() == 5) begin
         chk("rr_order0", 32'(ack_log[0]), 32'd0);
         chk("rr_order1", 32'(ack_log[1]), 32'd1);
         chk("rr_order2", 32'(ack_log[2]), 32'd2);
         chk("rr_order3", 32'(ack_log[3]), 32'd3);
         chk("rr_order4", 32'(ack_log[4]), 32'd1);
      end
      wait_idle("rr", 40);

      // Reset while BUSY with a stalled engine, then a fresh request
      eng_lat = 0;
      post(0, 3'b010, 32'h1, 32'h2);
      for (int k = 0; k < 20 && !(eng_clk_en && !eng_start); k++) tick();
      chk("reached_busy", {31'd0, eng_clk_en && !eng_start}, 32'd1);
      repeat (3) tick();
      apply_reset();
      eng_lat = 2;
      post(3, 3'b010, 32'h0, 32'h0000BEEF);
      wait_idle("post_reset", 40);
      chk("post_reset_id", 32'(last_id), 32'd3);
      chk("post_reset_res", last_res, 32'h0000BEEF);

`ifdef ACC_SEND_TIMEOUT_EN
      to_mode = 1;
      eng_lat = 0;
      post(2, 3'b010, 32'h9, 32'h0000ABCD);
      wait_idle("watchdog", 60);
      to_mode = 0;
      chk("to_err", 32'(last_err), 32'd3);
      chk("timeout_flag", 32'(timeout_flag), 32'd1);
      eng_lat = 2;
      post(0, 3'b010, 32'h0, 32'h42);
      wait_idle("after_to", 40);
      chk("timeout_flag_sticky", 32'(timeout_flag), 32'd1);
`endif

      // Random traffic, stray done pulses while idle
      for (int k = 0; k < 600; k++) begin
         tick();
         eng_lat    = $urandom_range(1, 6);
         stray_done = !busy && ($urandom_range(0, 7) == 0);
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
               int          sel;
               logic [2:0]  op;
               logic [31:0] p;
               sel = $urandom_range(0, 9);
               op  = (sel < 5) ? 3'b010 : (sel < 8) ? 3'b011 : 3'($urandom);
               p   = $urandom;
               if (op == 3'b011 && $urandom_range(0, 3) == 0) p[10:0] = 11'd0;
               post(i, op, $urandom, p);
            end
         end
      end
      stray_done = 1'b0;
      wait_idle("random_drain", 300);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
